// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the multicycle RV32I core.
//   - RV32I opcode, funct3 and funct7 constants
//   - ALU operation enum and the funct3/funct7 -> ALU op decoder
//   - FSM state enum
//   - immediate generator for all RV32I instruction formats
package core_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct3 for OP / OP-IMM
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 for branches
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct7: ALT selects SUB / SRA / SRAI
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_e;

    function automatic alu_op_e alu_op_decode(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

    // Sign-extended immediate; I-type is the fallback for every other opcode.
    function automatic logic [31:0] imm_gen(input logic [31:0] ir);
        logic [31:0] imm;
        case (ir[6:0])
            OPC_LUI, OPC_AUIPC: imm = {ir[31:12], 12'b0};
            OPC_JAL:            imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            OPC_BRANCH:         imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            OPC_STORE:          imm = {{21{ir[31]}}, ir[30:25], ir[11:7]};
            default:            imm = {{21{ir[31]}}, ir[30:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/core_alu.sv
// core_alu: combinational 32-bit integer ALU.
//   a, b   : operands
//   op     : operation select (alu_op_e)
//   result : operation result, modulo 2^32
//   eq     : a == b
//   lt     : a <  b, signed
//   ltu    : a <  b, unsigned
module core_alu
    import core_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        eq,
    output logic        lt,
    output logic        ltu
);

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_SLL:    result = a << b[4:0];
            ALU_SLT:    result = {31'b0, lt};
            ALU_SLTU:   result = {31'b0, ltu};
            ALU_XOR:    result = a ^ b;
            ALU_SRL:    result = a >> b[4:0];
            ALU_SRA:    result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:     result = a | b;
            ALU_AND:    result = a & b;
            ALU_PASS_B: result = b;
            default:    result = a + b;
        endcase
    end

endmodule

// File: rtl/core.sv
// core: multicycle RV32I integer core (FETCH/DECODE/EXECUTE/MEM/WRITEBACK).
//   clk      : clock, all state changes on rising edge
//   resetn   : asynchronous active-low reset
//   address  : fetch address (PC) or data address (rs1+imm) in MEM
//   data_out : store data, held between stores
//   data_in  : memory read word, valid in the same cycle as address
//   we       : memory write enable, high only in the MEM cycle of a store
// Data port is word-only: sub-word loads/stores behave as LW/SW.
module core
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] address,
    output logic [31:0] data_out,
    input  logic [31:0] data_in,
    output logic        we
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] rs1v_q, rs1v_d;
    logic [31:0] rs2v_q, rs2v_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] dout_q, dout_d;

    logic [31:0] regs_q [32];
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [31:0] alu_a, alu_b, alu_res;
    alu_op_e     alu_op;
    logic        cmp_eq, cmp_lt, cmp_ltu;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        br_taken;
    logic [31:0] jalr_sum;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    assign jalr_sum = rs1v_q + imm_q;

    core_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_res),
        .eq     (cmp_eq),
        .lt     (cmp_lt),
        .ltu    (cmp_ltu)
    );

    always_comb begin
        case (funct3)
            F3_BEQ:  br_taken = cmp_eq;
            F3_BNE:  br_taken = !cmp_eq;
            F3_BLT:  br_taken = cmp_lt;
            F3_BGE:  br_taken = !cmp_lt;
            F3_BLTU: br_taken = cmp_ltu;
            F3_BGEU: br_taken = !cmp_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        rs1v_d   = rs1v_q;
        rs2v_d   = rs2v_q;
        imm_d    = imm_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        dout_d   = dout_q;
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = alu_q;
        alu_a    = rs1v_q;
        alu_b    = rs2v_q;
        alu_op   = ALU_ADD;

        case (state_q)
            ST_FETCH: begin
                ir_d    = data_in;
                state_d = ST_DECODE;
            end

            ST_DECODE: begin
                rs1v_d  = (rs1 == 5'd0) ? '0 : regs_q[rs1];
                rs2v_d  = (rs2 == 5'd0) ? '0 : regs_q[rs2];
                imm_d   = imm_gen(ir_q);
                state_d = ST_EXECUTE;
            end

            ST_EXECUTE: begin
                // Fall-through PC is committed here for every instruction;
                // taken branches and jumps overwrite it below.
                pc_d    = pc_q + 32'd4;
                state_d = ST_FETCH;
                case (opcode)
                    OPC_LUI: begin
                        alu_b   = imm_q;
                        alu_op  = ALU_PASS_B;
                        alu_d   = alu_res;
                        state_d = ST_WRITEBACK;
                    end
                    OPC_AUIPC: begin
                        alu_a   = pc_q;
                        alu_b   = imm_q;
                        alu_d   = alu_res;
                        state_d = ST_WRITEBACK;
                    end
                    OPC_JAL, OPC_JALR: begin
                        // ALU produces the link value; target uses its own adder.
                        alu_a   = pc_q;
                        alu_b   = 32'd4;
                        alu_d   = alu_res;
                        pc_d    = (opcode == OPC_JAL) ? (pc_q + imm_q)
                                                      : {jalr_sum[31:1], 1'b0};
                        state_d = ST_WRITEBACK;
                    end
                    OPC_BRANCH: begin
                        if (br_taken) begin
                            pc_d = pc_q + imm_q;
                        end
                    end
                    OPC_LOAD: begin
                        alu_b   = imm_q;
                        alu_d   = alu_res;
                        state_d = ST_MEM;
                    end
                    OPC_STORE: begin
                        alu_b   = imm_q;
                        alu_d   = alu_res;
                        dout_d  = rs2v_q;
                        state_d = ST_MEM;
                    end
                    OPC_OP_IMM: begin
                        alu_b   = imm_q;
                        alu_op  = alu_op_decode(funct3,
                                      (funct3 == F3_SRL_SRA) && (funct7 == F7_ALT));
                        alu_d   = alu_res;
                        state_d = ST_WRITEBACK;
                    end
                    OPC_OP: begin
                        alu_op  = alu_op_decode(funct3, funct7 == F7_ALT);
                        alu_d   = alu_res;
                        state_d = ST_WRITEBACK;
                    end
                    default: ; // FENCE, SYSTEM and unknown opcodes: PC+4 only
                endcase
            end

            ST_MEM: begin
                if (opcode == OPC_STORE) begin
                    state_d = ST_FETCH;
                end else begin
                    mdr_d   = data_in;
                    state_d = ST_WRITEBACK;
                end
            end

            ST_WRITEBACK: begin
                rf_we    = (rd != 5'd0);
                rf_wdata = (opcode == OPC_LOAD) ? mdr_q : alu_q;
                state_d  = ST_FETCH;
            end

            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            rs1v_q  <= '0;
            rs2v_q  <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            rs1v_q  <= rs1v_d;
            rs2v_q  <= rs2v_d;
            imm_q   <= imm_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            dout_q  <= dout_d;
        end
    end

    // Entry 0 is never written, and reads of x0 are muxed to zero in DECODE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    // we decodes from state, so an asynchronous reset drops it immediately.
    assign address  = (state_q == ST_MEM) ? alu_q : pc_q;
    assign we       = (state_q == ST_MEM) && (opcode == OPC_STORE);
    assign data_out = dout_q;

endmodule

// File: tb/tb_core.sv
// tb_core: directed-program bench for core with a 1024-word memory model.
module tb_core;

    localparam logic [6:0] OPI   = 7'b0010011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] JALR  = 7'b1100111;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] address, data_out, data_in;
    logic        we;

    logic [31:0] mem [0:1023];
    logic        clr, ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_st;
    int          cyc;
    bit          done;
    logic [31:0] first_addr, first_data, end_addr, end_data;
    logic [31:0] p [$];

    always #5 clk = ~clk;

    core #(.RESET_PC(32'h0000_0000)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .address  (address),
        .data_out (data_out),
        .data_in  (data_in),
        .we       (we)
    );

    assign data_in = mem[address[11:2]];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hDEADBEEF;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (we) begin
            mem[address[11:2]] <= data_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [11:0] a);
        return mem[a[11:2]];
    endfunction

    // Instruction encoders. Branch/jump offsets are given as offset/2.
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [11:0] h, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {h[11], h[9:4], rs2, rs1, f3, h[3:0], h[10], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [19:0] h, input logic [4:0] rd);
        return {h[19], h[9:0], h[10], h[18:11], rd, 7'b1101111};
    endfunction

    // Holds the core in reset, fills memory with 0xDEADBEEF, then loads p.
    task automatic load();
        resetn = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        foreach (p[i]) begin
            ld_en   = 1'b1;
            ld_addr = 10'(i);
            ld_data = p[i];
            @(negedge clk);
        end
        ld_en = 1'b0;
    endtask

    // Releases reset just after a rising edge, so cycle 1 is the first FETCH,
    // and runs until a store to word 0xFFC or the cycle budget expires.
    task automatic run(input string tag, input int budget);
        @(posedge clk);
        #1 resetn = 1'b1;
        cyc = 0; n_st = 0; done = 1'b0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (we) begin
                n_st++;
                if (n_st == 1) begin
                    first_addr = address;
                    first_data = data_out;
                end
                if (address[11:0] == 12'hFFC) begin
                    done     = 1'b1;
                    end_addr = address;
                    end_data = data_out;
                end
            end
        end
        check({tag, ":finished"}, {31'b0, done}, 32'd1);
        @(posedge clk);
        #1 resetn = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; clr = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        // Reset window: 11 time units low
        #2 check("rst_addr_t2", address, 32'h0);
        check("rst_we_t2", {31'b0, we}, 32'd0);
        check("rst_dout_t2", data_out, 32'h0);
        #6 check("rst_addr_t8", address, 32'h0);
        check("rst_we_t8", {31'b0, we}, 32'd0);
        check("rst_dout_t8", data_out, 32'h0);
        #3 resetn = 1'b1;
        #1 check("first_fetch_addr", address, 32'h0);
        check("first_fetch_we", {31'b0, we}, 32'd0);
        resetn = 1'b0;

        // ADDI/ADDI/SW: 0x800 sign-extends to 0xFFFFF800 (word 0x200)
        p = '{enc_i(12'h005, 0, 0, 1, OPI), enc_i(12'hFFD, 1, 0, 2, OPI),
              enc_s(12'h800, 2, 0, 3'b010), enc_s(12'hFFC, 0, 0, 3'b010)};
        load();
        run("addi_sw", 60);
        check("addi_sw:stores", n_st, 2);
        check("addi_sw:addr", first_addr, 32'hFFFF_F800);
        check("addi_sw:data", first_data, 32'h0000_0002);
        check("addi_sw:mem800", word_at(12'h800), 32'h0000_0002);
        check("addi_sw:cycles", cyc, 16);

        // LUI/ADD overflow, signed vs unsigned compare
        p = '{enc_u(20'h80000, 1, LUI), enc_r(7'h00, 1, 1, 3'd0, 2),
              enc_i(12'hFFF, 0, 0, 3, OPI), enc_r(7'h00, 0, 3, 3'd2, 4),
              enc_r(7'h00, 0, 3, 3'd3, 5), enc_s(12'h800, 2, 0, 3'b010),
              enc_s(12'h804, 4, 0, 3'b010), enc_s(12'h808, 5, 0, 3'b010),
              enc_s(12'hFFC, 0, 0, 3'b010)};
        load();
        run("slt", 100);
        check("slt:mem800_add", word_at(12'h800), 32'h0);
        check("slt:mem804_slt", word_at(12'h804), 32'h1);
        check("slt:mem808_sltu", word_at(12'h808), 32'h0);

        // Shifts, XORI, SUB, branch polarity, AUIPC
        p = '{enc_i(12'hFF0, 0, 0, 1, OPI),  enc_i(12'h402, 1, 5, 2, OPI),
              enc_i(12'h01C, 1, 5, 3, OPI),  enc_i(12'h023, 0, 0, 4, OPI),
              enc_r(7'h00, 4, 3, 3'd1, 5),   enc_i(12'h0FF, 1, 4, 6, OPI),
              enc_r(7'h20, 1, 3, 3'd0, 7),   enc_s(12'h840, 2, 0, 3'b010),
              enc_s(12'h844, 5, 0, 3'b010),  enc_s(12'h848, 6, 0, 3'b010),
              enc_s(12'h84C, 7, 0, 3'b010),  enc_b(12'h004, 3, 1, 3'd6),
              enc_b(12'h004, 3, 1, 3'd5),    enc_b(12'h004, 3, 1, 3'd4),
              enc_s(12'h850, 1, 0, 3'b010),  enc_u(20'h00001, 9, AUIPC),
              enc_s(12'h854, 9, 0, 3'b010),  enc_s(12'hFFC, 0, 0, 3'b010)};
        load();
        run("alu", 200);
        check("alu:srai", word_at(12'h840), 32'hFFFF_FFFC);
        check("alu:sll_amt35", word_at(12'h844), 32'h0000_0078);
        check("alu:xori", word_at(12'h848), 32'hFFFF_FF0F);
        check("alu:sub", word_at(12'h84C), 32'h0000_001F);
        check("alu:blt_skip", word_at(12'h850), 32'hDEAD_BEEF);
        check("alu:auipc", word_at(12'h854), 32'h0000_103C);

        // Loop: three iterations of ADDI/BNE
        p = '{enc_i(12'h003, 0, 0, 2, OPI), enc_i(12'h001, 1, 0, 1, OPI),
              enc_b(12'hFFE, 2, 1, 3'd1),   enc_s(12'h80C, 1, 0, 3'b010),
              enc_s(12'hFFC, 0, 0, 3'b010)};
        load();
        run("loop", 100);
        check("loop:mem80c", word_at(12'h80C), 32'h3);
        check("loop:cycles", cyc, 33);

        // JAL/JALR link values, skipped slots, x0 write discarded
        p = '{enc_i(12'h005, 0, 0, 0, OPI), enc_i(12'h000, 0, 0, 0, OPI),
              enc_i(12'h000, 0, 0, 0, OPI), enc_i(12'h000, 0, 0, 0, OPI),
              enc_j(20'h00004, 1),          enc_s(12'h814, 1, 0, 3'b010),
              enc_s(12'h810, 1, 0, 3'b010), enc_i(12'h011, 1, 0, 2, JALR),
              enc_s(12'h81C, 1, 0, 3'b010), enc_u(20'h00000, 4, AUIPC),
              enc_s(12'h818, 4, 0, 3'b010), enc_s(12'h824, 2, 0, 3'b010),
              enc_s(12'h820, 0, 0, 3'b010), enc_s(12'hFFC, 0, 0, 3'b010)};
        load();
        run("jal", 150);
        check("jal:link", word_at(12'h810), 32'h0000_0014);
        check("jal:skip14", word_at(12'h814), 32'hDEAD_BEEF);
        check("jalr:target_bit0", word_at(12'h818), 32'h0000_0024);
        check("jalr:skip20", word_at(12'h81C), 32'hDEAD_BEEF);
        check("jalr:link", word_at(12'h824), 32'h0000_0020);
        check("x0:stays_zero", word_at(12'h820), 32'h0);

        // Store then LW, LB-as-LW, SB-as-SW, terminal store of loaded value
        p = '{enc_u(20'h12345, 1, LUI),      enc_i(12'h678, 1, 0, 1, OPI),
              enc_s(12'h800, 1, 0, 3'b010),  enc_i(12'h800, 0, 2, 6, LOAD),
              enc_i(12'h800, 0, 0, 7, LOAD), enc_s(12'h804, 7, 0, 3'b000),
              enc_s(12'hFFC, 6, 0, 3'b010)};
        load();
        run("lw", 100);
        check("lw:end_addr", end_addr, 32'hFFFF_FFFC);
        check("lw:end_data", end_data, 32'h1234_5678);
        check("lb_sb:mem804", word_at(12'h804), 32'h1234_5678);
        check("lw:cycles", cyc, 30);

        // Reset asserted during a store's MEM cycle must suppress the write
        p = '{enc_i(12'h007, 0, 0, 1, OPI), enc_s(12'h820, 1, 0, 3'b010),
              enc_s(12'hFFC, 0, 0, 3'b010)};
        load();
        @(posedge clk);
        #1 resetn = 1'b1;
        cyc = 0;
        while (!we && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("abort:we_seen_cycle", cyc, 8);
        resetn = 1'b0;
        #1 check("abort:we_low", {31'b0, we}, 32'd0);
        check("abort:dout_zero", data_out, 32'h0);
        check("abort:addr_reset", address, 32'h0);
        @(posedge clk);
        #1 check("abort:no_write", word_at(12'h820), 32'hDEAD_BEEF);

        // Registers cleared by that reset: x1 reads back as 0
        p = '{enc_s(12'h824, 1, 0, 3'b010), enc_s(12'hFFC, 0, 0, 3'b010)};
        load();
        run("rst_regs", 40);
        check("rst_regs:x1_zero", word_at(12'h824), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
